// File: rtl/alu_share_arb.sv
// alu_share_arb: arbiter and two-stage issue sequencer that lets two requesters
// share one combinational ALU.
//   Requester 0 is the execute stage. Requester 1 is the address-generation and
//   set-compare helper.
//   Ports:
//     clk, rst_n             clock and asynchronous active-low reset
//     flush                  synchronous kill of all in-flight operations
//     reqX_valid/op/a/b      request payload for requester X
//     req0_lock              requester 0 keeps priority for back-to-back ops
//     reqX_ready             combinational grant; accept = valid & ready
//     alu_op/alu_a/alu_b     registered issue-stage (S1) drive into the ALU
//     alu_result/alu_flag    combinational ALU return, captured into S2
//     rsp_valid/id/result/flag  registered response (S2), one pulse per op
//     busy                   S1 or S2 occupied
module alu_share_arb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_lock,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_flag,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             busy
);

    logic             gnt0_c;
    logic             gnt1_c;
    logic             rr_q;
    logic             rr_d;

    logic             s1_valid_q;
    logic             s1_valid_d;
    logic             s1_id_q;
    logic             s1_id_d;
    logic [OPW-1:0]   s1_op_q;
    logic [OPW-1:0]   s1_op_d;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_a_d;
    logic [WIDTH-1:0] s1_b_q;
    logic [WIDTH-1:0] s1_b_d;

    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic             rsp_id_q;
    logic             rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q;
    logic [WIDTH-1:0] rsp_result_d;
    logic             rsp_flag_q;
    logic             rsp_flag_d;

    // Grant: a lone requester wins; on contention rr_q picks; nothing during flush.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!flush) begin
            if (req0_valid && req1_valid) begin
                gnt0_c = ~rr_q;
                gnt1_c = rr_q;
            end else begin
                gnt0_c = req0_valid;
                gnt1_c = req1_valid;
            end
        end
    end

    // Pointer moves to the other requester, except requester 0 under lock keeps it.
    always_comb begin
        rr_d = rr_q;
        if (gnt0_c) begin
            rr_d = ~req0_lock;
        end else if (gnt1_c) begin
            rr_d = 1'b0;
        end
    end

    // Issue stage: an idle slot drives zeros, so the ALU computes ADD 0+0.
    always_comb begin
        s1_valid_d = gnt0_c | gnt1_c;
        s1_id_d    = 1'b0;
        s1_op_d    = '0;
        s1_a_d     = '0;
        s1_b_d     = '0;
        if (gnt0_c) begin
            s1_op_d = req0_op;
            s1_a_d  = req0_a;
            s1_b_d  = req0_b;
        end else if (gnt1_c) begin
            s1_id_d = 1'b1;
            s1_op_d = req1_op;
            s1_a_d  = req1_a;
            s1_b_d  = req1_b;
        end
    end

    // Response stage: capture the ALU output for a live S1 op unless flushed.
    always_comb begin
        rsp_valid_d  = s1_valid_q & ~flush;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        if (rsp_valid_d) begin
            rsp_id_d     = s1_id_q;
            rsp_result_d = alu_result;
            rsp_flag_d   = alu_flag;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_op_q      <= '0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
        end
    end

    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;
    assign alu_op     = s1_op_q;
    assign alu_a      = s1_a_q;
    assign alu_b      = s1_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed and random stimulus for alu_share_arb.
// Each op is scored against a queue of expected responses with due cycles.
module tb_alu_share_arb;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             req0_valid, req0_lock, req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_flag;
    logic             rsp_valid, rsp_id, rsp_flag, busy;
    logic [WIDTH-1:0] rsp_result;

    always #5 clk = ~clk;

    // Behavioural ALU, also used to predict responses.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [OPW-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[3:0];
            4'd6:    return a >> b[3:0];
            default: return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    function automatic logic flag_fn(input logic [OPW-1:0] op,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        case (op)
            4'd8:    return a == 16'd0;
            4'd9:    return a != 16'd0;
            4'd10:   return a[15];
            4'd11:   return a < b;
            4'd12:   return a == b;
            4'd13:   return a != b;
            4'd14:   return $signed(a) < $signed(b);
            4'd15:   return a >= b;
            default: return b[0];
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);
    assign alu_flag   = flag_fn(alu_op, alu_a, alu_b);

    alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flag(rsp_flag), .busy(busy)
    );

    typedef struct {
        int               due;
        logic             id;
        logic [WIDTH-1:0] res;
        logic             flag;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: expected responses in accept order, pointer, expected issue drive.
    exp_t             q[$];
    int               cyc = 0;
    bit               rr  = 1'b0;
    logic [OPW-1:0]   iss_op = '0;
    logic [WIDTH-1:0] iss_a  = '0;
    logic [WIDTH-1:0] iss_b  = '0;

    logic             last_rdy0, last_rdy1, last_rsp_valid, last_rsp_id, last_rsp_flag, last_busy;
    logic [WIDTH-1:0] last_rsp_result;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: called at posedge+1 with inputs set; checks at negedge, returns at posedge+1.
    task automatic tick();
        int   win;
        logic ev;
        logic fut;
        exp_t e;
        @(negedge clk);
        if (flush)                         win = -1;
        else if (req0_valid && req1_valid) win = rr ? 1 : 0;
        else if (req0_valid)               win = 0;
        else if (req1_valid)               win = 1;
        else                               win = -1;

        last_rdy0       = req0_ready;
        last_rdy1       = req1_ready;
        last_rsp_valid  = rsp_valid;
        last_rsp_id     = rsp_id;
        last_rsp_result = rsp_result;
        last_rsp_flag   = rsp_flag;
        last_busy       = busy;

        chk("req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(win == 1));
        chk("alu_op", 32'(alu_op), 32'(iss_op));
        chk("alu_a", 32'(alu_a), 32'(iss_a));
        chk("alu_b", 32'(alu_b), 32'(iss_b));

        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
            chk("rsp_flag", 32'(rsp_flag), 32'(q[0].flag));
            void'(q.pop_front());
        end
        fut = (q.size() > 0) && (q[0].due == cyc + 1);
        chk("busy", 32'(busy), 32'(ev | fut));

        if (flush) begin
            while (q.size() > 0 && q[0].due == cyc + 1) void'(q.pop_front());
        end

        iss_op = '0;
        iss_a  = '0;
        iss_b  = '0;
        if (win >= 0) begin
            iss_op = (win == 0) ? req0_op : req1_op;
            iss_a  = (win == 0) ? req0_a  : req1_a;
            iss_b  = (win == 0) ? req0_b  : req1_b;
            e.due  = cyc + 2;
            e.id   = (win == 1);
            e.res  = alu_fn(iss_op, iss_a, iss_b);
            e.flag = flag_fn(iss_op, iss_a, iss_b);
            q.push_back(e);
            rr = (win == 0) ? !req0_lock : 1'b0;
        end
        cyc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_lock  = 1'b0;
        flush      = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_lock = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

        // Reset state.
        #2;
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD from requester 0.
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 16'h0003; req0_b = 16'h0004;
        tick();
        chk("single_ready0", 32'(last_rdy0), 32'd1);
        req0_valid = 1'b0;
        tick();
        tick();
        chk("single_rsp_valid", 32'(last_rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(last_rsp_id), 32'd0);
        chk("single_rsp_result", 32'(last_rsp_result), 32'h0007);
        idle(1);

        // Branch flag from requester 1: BEQZ on zero and nonzero operand.
        req1_valid = 1'b1; req1_op = 4'b1000; req1_a = 16'h0000; req1_b = 16'h0000;
        tick();
        req1_a = 16'h0001;
        tick();
        req1_valid = 1'b0;
        tick();
        chk("beqz_zero_flag", 32'(last_rsp_flag), 32'd1);
        chk("beqz_zero_id", 32'(last_rsp_id), 32'd1);
        tick();
        chk("beqz_one_flag", 32'(last_rsp_flag), 32'd0);
        idle(1);

        // Contention without lock alternates 0,1,0,1.
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 16'h0100; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'h00f0; req1_b = 16'h000f;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("contend_grant0", 32'(last_rdy0), 32'(i % 2 == 0));
        end
        idle(3);

        // Lock: 0 keeps priority while locked; after an unlocked grant 1 wins.
        req0_valid = 1'b1; req1_valid = 1'b1; req0_lock = 1'b1;
        tick(); chk("lock_g1", 32'(last_rdy0), 32'd1);
        tick(); chk("lock_g2", 32'(last_rdy0), 32'd1);
        req0_lock = 1'b0;
        tick(); chk("lock_g3", 32'(last_rdy0), 32'd1);
        tick(); chk("lock_g4", 32'(last_rdy1), 32'd1);
        idle(3);

        // Flush kills the op in S1 and blocks the grant in the flush cycle.
        req0_valid = 1'b1; req1_valid = 1'b0; req0_op = 4'd4; req0_a = 16'h1234; req0_b = 16'h00ff;
        tick();
        flush = 1'b1;
        tick();
        chk("flush_ready0", 32'(last_rdy0), 32'd0);
        flush = 1'b0; req0_valid = 1'b0;
        tick();
        chk("flush_rsp_c2", 32'(last_rsp_valid), 32'd0);
        chk("flush_busy_c2", 32'(last_busy), 32'd0);
        tick();
        chk("flush_rsp_c3", 32'(last_rsp_valid), 32'd0);
        idle(1);

        // Async reset with S1 and S2 both occupied.
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'd0; req1_op = 4'd2;
        tick();
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_alu_a", 32'(alu_a), 32'd0);
        chk("arst_alu_b", 32'(alu_b), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rsp_result", 32'(rsp_result), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        q.delete();
        rr = 1'b0; iss_op = '0; iss_a = '0; iss_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        chk("arst_next_grant0", 32'(last_rdy0), 32'd1);
        idle(3);

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_lock  = ($urandom_range(0, 9) < 3);
            flush      = ($urandom_range(0, 19) == 0);
            req0_op    = OPW'($urandom);
            req1_op    = OPW'($urandom);
            req0_a     = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            req1_a     = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            req0_b     = WIDTH'($urandom);
            req1_b     = WIDTH'($urandom);
            tick();
        end
        idle(3);
        chk("drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
